niosii_sys_tick_service: RTL and testbench

Hardware tick-service stage that sits directly downstream of the system interval timer. It drives the timer's Avalon-MM slave as a master, so the CPU never touches the timer. At reset it starts the timer in continuous, interrupt-enabled mode, then services every timer interrupt by clearing the timeout status and counting the tick. It also takes counter snapshots on request and exposes a 32-bit tick count, an alarm compare with its own interrupt, and the snapshot through a CPU-facing Avalon-MM slave.

---
 rtl/niosii_sys_tick_service.sv | 109 ++++++++++
 tb/tb_niosii_sys_tick_service.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_sys_tick_service.sv
// niosii_sys_tick_service: services the interval timer's interrupts, counts ticks and exposes tick/alarm/snapshot registers to the CPU
// Ports: clk/reset; CPU slave (address, chipselect, write_n, writedata, readdata, irq);
// timer master (tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata, tmr_readdata, tmr_irq).
module niosii_sys_tick_service #(
  parameter logic [31:0] TICK_RESET  = 32'h0000_0000,
  parameter logic [31:0] ALARM_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);
  typedef enum logic [3:0] {INIT, IDLE, ACK, SETTLE, CMD, SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE} state_t;
  // state decides; bus is the state whose access is on the timer bus this cycle
  state_t state, next_state, bus;
  logic [31:0] tick_count, alarm_val, tick_inc, rd;
  logic [16:0] snapshot;
  logic run, aie, alarm, cmd_pend, cmd_start, snap_pend;
  logic wr, wr_ticks, wr_ctrl, wr_alarm, wr_status, cmd_wr, ack_now, alarm_hit;
  logic cs_d, wn_d;
  logic [2:0] addr_d;
  logic [15:0] data_d;
  assign wr        = chipselect & ~write_n;
  assign wr_ticks  = wr && address == 3'd0;
  assign wr_ctrl   = wr && address == 3'd1;
  assign wr_alarm  = wr && address == 3'd2;
  assign wr_status = wr && address == 3'd3;
  assign cmd_wr    = wr_ctrl && writedata[0] != run;
  assign tick_inc  = tick_count + 32'd1;
  assign ack_now   = bus == ACK;
  // a TICKS write in the same cycle as the ack discards that tick entirely
  assign alarm_hit = ack_now && !wr_ticks && tick_inc == alarm_val;
  assign irq       = alarm & aie;
  always_comb begin
    next_state = state;
    unique case (state)
      INIT:      next_state = SETTLE;
      // the snapshot flag is still set on the cycle its final read retires
      IDLE:      next_state = tmr_irq ? ACK : cmd_pend ? CMD : (snap_pend && bus != SNAP_DONE) ? SNAP_W : IDLE;
      ACK:       next_state = SETTLE;
      SETTLE:    next_state = IDLE;
      CMD:       next_state = SETTLE;
      SNAP_W:    next_state = SNAP_RL;
      SNAP_RL:   next_state = SNAP_RH;
      SNAP_RH:   next_state = SNAP_DONE;
      SNAP_DONE: next_state = IDLE;
      default:   next_state = INIT;
    endcase
  end
  always_comb begin
    cs_d   = state inside {INIT, ACK, CMD, SNAP_W, SNAP_RL, SNAP_RH};
    wn_d   = !(state inside {INIT, ACK, CMD, SNAP_W});
    addr_d = (state inside {INIT, CMD}) ? 3'd1 : (state inside {SNAP_W, SNAP_RL}) ? 3'd4 : state == SNAP_RH ? 3'd5 : 3'd0;
    data_d = (state == INIT || (state == CMD && cmd_start)) ? 16'h0007 : state == CMD ? 16'h0008 : 16'h0000;
    rd     = address == 3'd0 ? tick_count :
             address == 3'd1 ? {29'h0, snap_pend, aie, run} :
             address == 3'd2 ? alarm_val :
             address == 3'd3 ? {30'h0, state != IDLE, alarm} :
             address == 3'd4 ? {15'h0, snapshot} : 32'h0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= INIT;
      bus            <= IDLE;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'h0;
      tick_count     <= TICK_RESET;
      alarm_val      <= ALARM_RESET;
      run            <= 1'b1;
      aie            <= 1'b0;
      alarm          <= 1'b0;
      cmd_pend       <= 1'b0;
      cmd_start      <= 1'b0;
      snap_pend      <= 1'b0;
      snapshot       <= 17'h0;
      readdata       <= 32'h0;
    end else begin
      state          <= next_state;
      bus            <= state;
      tmr_chipselect <= cs_d;
      tmr_write_n    <= wn_d;
      tmr_address    <= addr_d;
      tmr_writedata  <= data_d;
      tick_count     <= wr_ticks ? 32'h0 : ack_now ? tick_inc : tick_count;
      alarm          <= alarm_hit | (alarm & ~(wr_status & writedata[0]));
      alarm_val      <= wr_alarm ? writedata : alarm_val;
      run            <= wr_ctrl ? writedata[0] : run;
      aie            <= wr_ctrl ? writedata[1] : aie;
      cmd_pend       <= cmd_wr | (cmd_pend & (state != CMD));
      cmd_start      <= cmd_wr ? writedata[0] : cmd_start;
      snap_pend      <= (wr_ctrl & writedata[2]) | (snap_pend & (bus != SNAP_DONE));
      snapshot[15:0] <= bus == SNAP_RH ? tmr_readdata : snapshot[15:0];
      snapshot[16]   <= bus == SNAP_DONE ? tmr_readdata[0] : snapshot[16];
      readdata       <= (chipselect && write_n) ? rd : 32'h0;
    end
  end
endmodule

// File: tb/tb_niosii_sys_tick_service.sv
// tb_niosii_sys_tick_service: directed plus randomized checks of the tick service against a counting model
module tb_niosii_sys_tick_service;
  logic clk = 0, reset = 1;
  logic [2:0] address = 0;
  logic chipselect = 0, write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] readdata, readdata2;
  logic irq, irq2;
  logic [2:0] tmr_address, tmr_address2;
  logic tmr_chipselect, tmr_chipselect2, tmr_write_n, tmr_write_n2;
  logic [15:0] tmr_writedata, tmr_writedata2;
  logic [15:0] tmr_readdata = 0;
  logic tmr_irq = 0, raise = 0;
  logic [16:0] snap_val = 0, latched = 0;
  logic [19:0] log_q[$];
  int checks = 0, failures = 0, busy_cnt;
  logic [31:0] m_ticks, m_alarm_val, rd, rd2;
  logic m_alarm, m_aie;
  logic [16:0] m_snap;

  always #5 clk = ~clk;

  niosii_sys_tick_service u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq), .tmr_address(tmr_address),
    .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq));

  niosii_sys_tick_service #(.TICK_RESET(32'hFFFF_FFFF)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata2), .irq(irq2), .tmr_address(tmr_address2),
    .tmr_chipselect(tmr_chipselect2), .tmr_write_n(tmr_write_n2), .tmr_writedata(tmr_writedata2),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq));

  // timer model: timeout flag cleared by a write to address 0, snapshot latched by a write to address 4
  always @(posedge clk) begin
    if (tmr_chipselect) log_q.push_back({~tmr_write_n, tmr_address, tmr_writedata});
    if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd4) latched <= snap_val;
    tmr_irq <= (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) ? 1'b0 : (tmr_irq | raise);
    tmr_readdata <= !(tmr_chipselect && tmr_write_n) ? 16'h0 : tmr_address == 3'd4 ? latched[15:0] :
                    tmr_address == 3'd5 ? {15'h0, latched[16]} : 16'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return i < log_q.size() ? {12'h0, log_q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] bus_now();
    return {11'h0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask

  task automatic cpu_read(input logic [2:0] a);
    address = a; chipselect = 1; write_n = 1;
    @(negedge clk);
    chipselect = 0; rd = readdata; rd2 = readdata2;
  endtask

  task automatic tick_event();
    raise = 1;
    @(negedge clk);
    raise = 0;
    wait_cyc(8);
    m_ticks++;
    if (m_ticks == m_alarm_val) m_alarm = 1;
  endtask

  initial begin
    m_ticks = 0; m_alarm_val = 32'hFFFF_FFFF; m_alarm = 0; m_aie = 0; m_snap = 0;
    wait_cyc(3);
    check("rst_bus", bus_now(), {11'h0, 1'b0, 1'b1, 3'd0, 16'h0});
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    log_q.delete();
    reset = 0;
    @(negedge clk);
    check("init_bus_cycle1", bus_now(), {11'h0, 1'b1, 1'b0, 3'd1, 16'h0007});
    wait_cyc(3);
    check("init_log_len", log_q.size(), 1);
    cpu_read(1); check("ctrl_reset", rd, 32'h1);
    cpu_read(0); check("ticks_reset", rd, m_ticks); check("ticks2_reset", rd2, 32'hFFFF_FFFF);
    // single interrupt, watching BUSY every cycle
    log_q.delete(); busy_cnt = 0;
    address = 3; chipselect = 1; write_n = 1; raise = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      raise = 0;
      busy_cnt += int'(readdata[1]);
    end
    chipselect = 0; m_ticks++;
    check("busy_cycles", busy_cnt, 2);
    check("alarm2_none", {31'h0, readdata2[0]}, 32'h0);
    check("ack_log_len", log_q.size(), 1);
    check("ack_log", log_at(0), {12'h0, 1'b1, 3'd0, 16'h0});
    cpu_read(0); check("ticks_one", rd, m_ticks); check("ticks2_wrap", rd2, 32'h0);
    // alarm after three ticks
    cpu_write(0, 0); m_ticks = 0;
    cpu_write(2, 3); m_alarm_val = 3;
    cpu_write(1, 3); m_aie = 1;
    for (int i = 0; i < 3; i++) begin
      tick_event();
      check("alarm_irq", {31'h0, irq}, {31'h0, m_alarm & m_aie});
    end
    cpu_write(3, 1); m_alarm = 0;
    check("w1c_irq", {31'h0, irq}, 32'h0);
    // W1C on the very edge the alarm sets: set wins
    cpu_write(0, 0); m_ticks = 0;
    cpu_write(2, 1); m_alarm_val = 1;
    raise = 1; @(negedge clk); raise = 0; wait_cyc(2);
    cpu_write(3, 1); m_ticks = 1; m_alarm = 1;
    wait_cyc(6);
    check("coinc_irq", {31'h0, irq}, {31'h0, m_alarm & m_aie});
    cpu_read(3); check("coinc_status", {31'h0, rd[0]}, {31'h0, m_alarm});
    // TICKS clear on the very edge of the ack: clear wins
    cpu_write(3, 1); m_alarm = 0;
    raise = 1; @(negedge clk); raise = 0; wait_cyc(2);
    cpu_write(0, 0); m_ticks = 0;
    wait_cyc(6);
    cpu_read(0); check("clear_wins", rd, m_ticks);
    // directed snapshot
    snap_val = 17'h1869F; log_q.delete();
    cpu_write(1, 32'h7);
    cpu_read(1); check("snap_pending", {31'h0, rd[2]}, 32'h1);
    wait_cyc(8); m_snap = snap_val;
    check("snap_log_len", log_q.size(), 3);
    check("snap_log0", log_at(0), {12'h0, 1'b1, 3'd4, 16'h0});
    check("snap_log1", log_at(1), {12'h0, 1'b0, 3'd4, 16'h0});
    check("snap_log2", log_at(2), {12'h0, 1'b0, 3'd5, 16'h0});
    cpu_read(4); check("snapshot", rd, {15'h0, m_snap});
    cpu_read(1); check("snap_cleared", rd, {29'h0, 1'b0, m_aie, 1'b1});
    // randomized operations against the model
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: tick_event();
        1: begin
          snap_val = 17'($urandom);
          cpu_write(1, {29'h0, 1'b1, m_aie, 1'b1});
          wait_cyc(10);
          m_snap = snap_val;
        end
        2: begin
          m_alarm_val = m_ticks + $urandom_range(0, 3);
          cpu_write(2, m_alarm_val);
        end
        3: begin
          cpu_write(3, 1);
          m_alarm = 0;
        end
        default: begin
          m_aie = 1'($urandom_range(0, 1));
          cpu_write(1, {30'h0, m_aie, 1'b1});
        end
      endcase
      wait_cyc(2);
      check("rand_irq", {31'h0, irq}, {31'h0, m_alarm & m_aie});
      cpu_read(0); check("rand_ticks", rd, m_ticks);
      if (it % 8 == 7) begin
        cpu_read(4); check("rand_snapshot", rd, {15'h0, m_snap});
        cpu_read(2); check("rand_alarm_val", rd, m_alarm_val);
        cpu_read(3); check("rand_status", rd, {30'h0, 1'b0, m_alarm});
      end
    end
    // stop requested while the timer interrupt is up: ack first, then stop
    log_q.delete();
    raise = 1;
    cpu_write(1, {30'h0, m_aie, 1'b0});
    raise = 0;
    wait_cyc(12);
    m_ticks++;
    if (m_ticks == m_alarm_val) m_alarm = 1;
    check("stop_log_len", log_q.size(), 2);
    check("stop_log0", log_at(0), {12'h0, 1'b1, 3'd0, 16'h0});
    check("stop_log1", log_at(1), {12'h0, 1'b1, 3'd1, 16'h0008});
    cpu_read(0); check("stop_ticks", rd, m_ticks);
    cpu_read(1); check("stop_ctrl", rd, {30'h0, m_aie, 1'b0});
    log_q.delete();
    cpu_write(1, {30'h0, m_aie, 1'b1});
    wait_cyc(4);
    check("start_log_len", log_q.size(), 1);
    check("start_log", log_at(0), {12'h0, 1'b1, 3'd1, 16'h0007});
    // reset in the middle of a snapshot
    snap_val = 17'h0ABCD;
    cpu_write(1, {29'h0, 1'b1, m_aie, 1'b1});
    wait_cyc(2);
    check("mid_snap_active", {31'h0, tmr_chipselect}, 32'h1);
    reset = 1;
    #1;
    check("midrst_bus", bus_now(), {11'h0, 1'b0, 1'b1, 3'd0, 16'h0});
    check("midrst_irq", {31'h0, irq}, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    @(negedge clk);
    log_q.delete();
    reset = 0;
    m_ticks = 0; m_alarm = 0; m_aie = 0; m_alarm_val = 32'hFFFF_FFFF; m_snap = 0;
    @(negedge clk);
    check("reinit_bus", bus_now(), {11'h0, 1'b1, 1'b0, 3'd1, 16'h0007});
    wait_cyc(3);
    check("reinit_log_len", log_q.size(), 1);
    cpu_read(4); check("reinit_snapshot", rd, {15'h0, m_snap});
    cpu_read(0); check("reinit_ticks", rd, m_ticks);
    cpu_read(1); check("reinit_ctrl", rd, 32'h1);
    cpu_read(2); check("reinit_alarm_val", rd, m_alarm_val);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
